// File: rtl/div_sequencer_if.sv
// Execute-stage <-> divide sequencer signal bundle.
// master: pipeline side (request, operands, flush); slave: the sequencer.
interface div_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic                 startE;
   logic                 signedE;
   logic [WIDTH-1:0]     srcaE;
   logic [WIDTH-1:0]     srcbE;
   logic                 flushE;
   logic                 stallE;
   logic                 validE;
   logic [2*WIDTH-1:0]   hiloresE;
   logic                 busy;

   modport master (
      output startE, signedE, srcaE, srcbE, flushE,
      input  stallE, validE, hiloresE, busy
   );

   modport slave (
      input  startE, signedE, srcaE, srcbE, flushE,
      output stallE, validE, hiloresE, busy
   );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU controller for the Execute stage: radix-2 restoring
// divider on operand magnitudes, signed fix-up on completion, and a
// one-cycle result pulse on {hi = remainder, lo = quotient}.
module div_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset,
   div_sequencer_if.slave bus
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic [2*WIDTH-1:0] hilo_q, hilo_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   rem_step, quo_step;
   logic [WIDTH-1:0]   q_fix, r_fix;

   // Operand magnitudes and one restoring step with sign fix-up of its result.
   always_comb begin
      a_mag = (bus.signedE && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
      b_mag = (bus.signedE && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;

      rem_sh = {rem_q, quo_q[WIDTH-1]};
      // Since rem < divisor, the shifted remainder is below 2*divisor, so
      // bit WIDTH of the WIDTH+1-bit difference is exactly the borrow.
      diff   = rem_sh - {1'b0, dvs_q};
      if (diff[WIDTH]) begin
         rem_step = rem_sh[WIDTH-1:0];
         quo_step = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
         rem_step = diff[WIDTH-1:0];
         quo_step = {quo_q[WIDTH-2:0], 1'b1};
      end

      q_fix = negq_q ? -quo_step : quo_step;
      r_fix = negr_q ? -rem_step : rem_step;
   end

   // Next-state and datapath register updates.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      hilo_d  = hilo_q;

      case (state_q)
         S_IDLE: begin
            if (bus.startE && !bus.flushE) begin
               dvs_d  = b_mag;
               quo_d  = a_mag;
               rem_d  = '0;
               cnt_d  = '0;
               negq_d = bus.signedE & (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
               negr_d = bus.signedE & bus.srcaE[WIDTH-1];
               if (bus.srcbE == '0) begin
                  hilo_d  = {bus.srcaE, {WIDTH{1'b1}}};
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               hilo_d  = {r_fix, q_fix};
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (bus.flushE) begin
         state_d = S_IDLE;
         hilo_d  = hilo_q;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         hilo_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         hilo_q  <= hilo_d;
      end
   end

   // Pipeline-facing status outputs.
   always_comb begin
      bus.stallE   = bus.startE & (state_q != S_DONE) & ~bus.flushE & ~reset;
      bus.validE   = (state_q == S_DONE) & ~bus.flushE & ~reset;
      bus.busy     = (state_q != S_IDLE);
      bus.hiloresE = hilo_q;
   end
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer (WIDTH = 32).
module tb_div_sequencer;
   logic clk;
   logic reset;
   int   tests;
   int   fails;
   logic [63:0] sb[$];
   logic [63:0] last_result;

   div_sequencer_if #(.WIDTH(32)) bus ();

   div_sequencer #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "time limit");
   end

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sg);
      longint sa, sbv, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (!sg) return {a % b, a / b};
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      q   = sa / sbv;
      r   = sa % sbv;
      return {r[31:0], q[31:0]};
   endfunction

   // Drive one request at a drive point and wait for its result pulse.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input logic [63:0] exp, input int exp_done, input string name);
      logic [63:0] want;
      int  stalls;
      bit  seen;
      sb.push_back(exp);
      bus.startE  = 1'b1;
      bus.signedE = sg;
      bus.srcaE   = a;
      bus.srcbE   = b;
      stalls = 0;
      seen   = 1'b0;
      for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
         #1;
         if (bus.stallE === 1'b1) stalls++;
         if (bus.validE === 1'b1) begin
            seen = 1'b1;
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL %s_sb: validE with empty scoreboard, required pending entry", name);
            end else begin
               want = sb.pop_front();
               last_result = want;
               if (bus.hiloresE !== want) begin
                  fails++;
                  $display("FAIL %s_result: hiloresE got %h required %h", name, bus.hiloresE, want);
               end
            end
            tests++;
            if (cyc !== exp_done) begin
               fails++;
               $display("FAIL %s_latency: DONE cycle got %0d required %0d", name, cyc, exp_done);
            end
            tests++;
            if (stalls !== exp_done) begin
               fails++;
               $display("FAIL %s_stalls: stall cycles got %0d required %0d", name, stalls, exp_done);
            end
            tests++;
            if (bus.stallE !== 1'b0) begin
               fails++;
               $display("FAIL %s_done_stall: stallE in DONE got %b required 0", name, bus.stallE);
            end
         end
         @(posedge clk);
         #1;
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: validE got none in 100 cycles, required pulse", name);
      end
   endtask

   task automatic end_request(input string name);
      bus.startE = 1'b0;
      #1;
      tests++;
      if (bus.busy !== 1'b0 || bus.validE !== 1'b0) begin
         fails++;
         $display("FAIL %s_after: busy/validE got %b/%b required 0/0", name, bus.busy, bus.validE);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.startE = 1'b1;
      bus.srcaE  = 32'd5;
      bus.srcbE  = 32'd1;
      #1;
      tests++;
      if (bus.stallE !== 1'b0) begin
         fails++;
         $display("FAIL reset_stall: stallE during reset got %b required 0", bus.stallE);
      end
      repeat (2) @(posedge clk);
      #1;
      bus.startE = 1'b0;
      reset = 1'b0;
      #1;
      tests++;
      if ({bus.validE, bus.busy, bus.stallE} !== 3'b000 || bus.hiloresE !== 64'd0) begin
         fails++;
         $display("FAIL reset_state: valid/busy/stall/hilo got %b%b%b/%h required 000/0",
                  bus.validE, bus.busy, bus.stallE, bus.hiloresE);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_divu();
      do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "divu_100_7");
      end_request("divu_100_7");
   endtask

   task automatic test_div_signed();
      do_div(32'hFFFF_FFF9, 32'h2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
      end_request("div_m7_2");
      do_div(32'h7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, 33, "div_7_m2");
      end_request("div_7_m2");
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33, "div_ovf");
      end_request("div_ovf");
   endtask

   task automatic test_div_zero();
      do_div(32'h1234, 32'h0, 1'b0, {32'h1234, 32'hFFFF_FFFF}, 1, "divu_zero");
      end_request("divu_zero");
   endtask

   task automatic test_back_to_back();
      do_div(32'd10, 32'd3, 1'b0, {32'd1, 32'd3}, 33, "b2b_first");
      do_div(32'd9, 32'd4, 1'b0, {32'd1, 32'd2}, 33, "b2b_second");
      end_request("b2b_second");
   endtask

   // Start a long divide, then cancel it at overall cycle 10 by flush or reset.
   task automatic test_abort(input bit use_reset, input string name);
      int bad;
      bus.startE  = 1'b1;
      bus.signedE = 1'b0;
      bus.srcaE   = 32'h0000_FFFF;
      bus.srcbE   = 32'd3;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
      end
      if (use_reset) reset = 1'b1;
      else bus.flushE = 1'b1;
      #1;
      tests++;
      if (bus.stallE !== 1'b0 || bus.validE !== 1'b0) begin
         fails++;
         $display("FAIL %s_same: stall/valid got %b/%b required 0/0", name, bus.stallE, bus.validE);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.flushE = 1'b0;
      bus.startE = 1'b0;
      if (use_reset) last_result = 64'd0;
      #1;
      tests++;
      if (bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL %s_idle: busy got %b required 0", name, bus.busy);
      end
      tests++;
      if (bus.hiloresE !== last_result) begin
         fails++;
         $display("FAIL %s_hilo: hiloresE got %h required %h", name, bus.hiloresE, last_result);
      end
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.validE !== 1'b0 || bus.stallE !== 1'b0) bad++;
         @(posedge clk);
         #1;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL %s_quiet: cycles with valid/stall got %0d required 0", name, bad);
      end
   endtask

   task automatic test_start_flush();
      bus.startE  = 1'b1;
      bus.flushE  = 1'b1;
      bus.signedE = 1'b0;
      bus.srcaE   = 32'd50;
      bus.srcbE   = 32'd5;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests++;
         if (bus.stallE !== 1'b0 || bus.busy !== 1'b0 || bus.validE !== 1'b0) begin
            fails++;
            $display("FAIL start_flush_%0d: stall/busy/valid got %b/%b/%b required 0/0/0",
                     c, bus.stallE, bus.busy, bus.validE);
         end
         @(posedge clk);
         #1;
      end
      bus.startE = 1'b0;
      bus.flushE = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic sg;
      for (int i = 0; i < 4; i++) begin
         a  = $urandom;
         b  = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
         sg = 1'($urandom_range(0, 1));
         do_div(a, b, sg, ref_div(a, b, sg), (b == 32'd0) ? 1 : 33, "random");
         end_request("random");
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      last_result = 64'd0;
      reset       = 1'b1;
      bus.startE  = 1'b0;
      bus.signedE = 1'b0;
      bus.srcaE   = '0;
      bus.srcbE   = '0;
      bus.flushE  = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_divu();
      test_div_signed();
      test_div_zero();
      test_back_to_back();
      test_abort(1'b0, "flush_run");
      test_abort(1'b1, "reset_run");
      test_start_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
